// File: rtl/rom_stream_reader_if.sv
// ROM access and valid/ready byte-stream signals shared by the reader and its neighbours.
// master: the reader side; slave: ROM model plus downstream consumer.
interface rom_stream_reader_if #(
    parameter int unsigned data_width    = 8,
    parameter int unsigned address_width = 4
);
    logic [address_width-1:0] address;
    logic                     read_enable;
    logic                     chip_enable;
    logic [data_width-1:0]    rom_data;
    logic [data_width-1:0]    data_out;
    logic                     data_valid;
    logic                     data_ready;
    logic                     last;

    modport master (
        output address, read_enable, chip_enable, data_out, data_valid, last,
        input  rom_data, data_ready
    );

    modport slave (
        input  address, read_enable, chip_enable, data_out, data_valid, last,
        output rom_data, data_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a ROM address range on request and streams each registered word
// over a valid/ready interface with a last-beat marker.
module rom_stream_reader #(
    parameter int unsigned data_width    = 8,
    parameter int unsigned memory_depth  = 16,
    parameter int unsigned address_width = $clog2(memory_depth)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [address_width-1:0] start_address,
    input  logic [address_width:0]   length,
    output logic                     busy,
    output logic                     done,
    rom_stream_reader_if.master      bus
);

    localparam int unsigned cnt_width = address_width + 1;
    localparam logic [address_width-1:0] last_address = address_width'(memory_depth - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t                   state;
    logic [address_width-1:0] addr_q;
    logic [cnt_width-1:0]     remaining_q;
    logic [data_width-1:0]    data_q;
    logic                     valid_q;
    logic                     last_q;
    logic                     rom_en_q;
    logic [address_width-1:0] next_addr;

    // Explicit wrap so non-power-of-2 depths stay inside the ROM.
    assign next_addr = (addr_q == last_address) ? '0 : addr_q + address_width'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            rom_en_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            addr_q      <= start_address;
                            remaining_q <= length;
                            rom_en_q    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    data_q   <= bus.rom_data;
                    last_q   <= (remaining_q == cnt_width'(1));
                    valid_q  <= 1'b1;
                    rom_en_q <= 1'b0;
                    state    <= SEND;
                end
                SEND: begin
                    // Beat is held untouched until the consumer takes it.
                    if (bus.data_ready) begin
                        valid_q     <= 1'b0;
                        last_q      <= 1'b0;
                        remaining_q <= remaining_q - cnt_width'(1);
                        if (remaining_q == cnt_width'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            addr_q   <= next_addr;
                            rom_en_q <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.address     = addr_q;
    assign bus.read_enable = rom_en_q;
    assign bus.chip_enable = rom_en_q;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.last        = last_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a 16-entry ROM holding "JARI" at 0-3.
module tb_rom_stream_reader;

    localparam int unsigned dw    = 8;
    localparam int unsigned depth = 16;
    localparam int unsigned aw    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [aw-1:0] start_address;
    logic [aw:0]   length;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int re_count = 0;
    int ce_count = 0;
    int done_count = 0;
    int dc, cc, rc;
    logic [7:0] d4 [4];

    rom_stream_reader_if #(.data_width(dw), .address_width(aw)) bus ();

    rom_stream_reader #(
        .data_width(dw), .memory_depth(depth), .address_width(aw)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_address(start_address),
        .length(length), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [3:0] a);
        case (a)
            4'd0:    return 8'h4A;
            4'd1:    return 8'h41;
            4'd2:    return 8'h52;
            4'd3:    return 8'h49;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.rom_data = rom_f(bus.address);

    always @(negedge clk) begin
        if (bus.read_enable) re_count++;
        if (bus.chip_enable) ce_count++;
        if (done) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] sa, input logic [4:0] len);
        start = 1'b1;
        start_address = sa;
        length = len;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, 32'(bus.data_valid), 32'(1'b1));
        check({tag, "_data"}, 32'(bus.data_out), 32'(d));
        check({tag, "_last"}, 32'(bus.last), 32'(l));
    endtask

    // Four-beat burst with ready high; optionally pulses start mid-burst.
    task automatic run_burst(input string tag, input logic [3:0] sa,
                             input logic [7:0] exp_d [4], input bit poke);
        launch(sa, 5'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_fetch"}, 32'({bus.chip_enable, bus.read_enable, bus.address}),
                  32'({2'b11, sa + 4'(i)}));
            step();
            beat(tag, exp_d[i], i == 3);
            if (poke && i == 1) begin
                start = 1'b1;
                start_address = 4'd9;
                length = 5'd1;
            end
            if (poke && i == 2) start = 1'b0;
            step();
        end
        check({tag, "_done"}, 32'({done, bus.data_valid, busy}), 32'(3'b100));
        step();
        check({tag, "_idle"}, 32'({done, busy}), 32'(2'b00));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_address = '0;
        length = '0;
        bus.data_ready = 1'b0;
        step();
        step();
        check("reset_outs", 32'({busy, done, bus.address, bus.read_enable, bus.chip_enable,
                                 bus.data_out, bus.data_valid, bus.last}), 32'(0));

        // Reset asserted mid-FETCH clears everything asynchronously.
        rst_n = 1'b1;
        step();
        launch(4'd2, 5'd4);
        check("fetch_pre_rst", 32'({busy, bus.chip_enable, bus.read_enable, bus.address}),
              32'({3'b111, 4'd2}));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fetch", 32'({busy, done, bus.address, bus.read_enable, bus.chip_enable,
                                      bus.data_out, bus.data_valid, bus.last}), 32'(0));
        step();
        rst_n = 1'b1;
        step();

        // Basic burst.
        bus.data_ready = 1'b1;
        dc = done_count;
        d4 = '{8'h4A, 8'h41, 8'h52, 8'h49};
        run_burst("basic", 4'd0, d4, 1'b0);
        check("basic_done_cnt", 32'(done_count), 32'(dc + 1));

        // Backpressure on the second beat.
        dc = done_count;
        launch(4'd0, 5'd4);
        step();
        beat("bp0", 8'h4A, 1'b0);
        step();
        bus.data_ready = 1'b0;
        step();
        beat("bp1", 8'h41, 1'b0);
        rc = re_count;
        for (int k = 0; k < 5; k++) begin
            step();
            beat("bp_stall", 8'h41, 1'b0);
            check("bp_stall_re", 32'({bus.read_enable, bus.chip_enable}), 32'(0));
        end
        bus.data_ready = 1'b1;
        step();
        check("bp_fetch2", 32'({bus.read_enable, bus.address}), 32'({1'b1, 4'd2}));
        check("bp_re_count", 32'(re_count), 32'(rc));
        step();
        beat("bp2", 8'h52, 1'b0);
        step();
        check("bp_fetch3", 32'({bus.read_enable, bus.address}), 32'({1'b1, 4'd3}));
        step();
        beat("bp3", 8'h49, 1'b1);
        step();
        check("bp_done", 32'({done, bus.data_valid, busy}), 32'(3'b100));
        step();
        check("bp_done_cnt", 32'(done_count), 32'(dc + 1));

        // Wrap-around past the top of the ROM.
        d4 = '{8'h00, 8'h00, 8'h4A, 8'h41};
        run_burst("wrap", 4'd14, d4, 1'b0);

        // Zero length: immediate done, no ROM access.
        cc = ce_count;
        dc = done_count;
        launch(4'd5, 5'd0);
        check("zero_done", 32'({done, busy, bus.chip_enable, bus.data_valid}), 32'(4'b1000));
        step();
        check("zero_idle", 32'({done, busy}), 32'(2'b00));
        check("zero_ce_cnt", 32'(ce_count), 32'(cc));
        check("zero_done_cnt", 32'(done_count), 32'(dc + 1));

        // Start pulsed during a burst is ignored.
        dc = done_count;
        d4 = '{8'h4A, 8'h41, 8'h52, 8'h49};
        run_burst("ignore", 4'd0, d4, 1'b1);
        check("ignore_done_cnt", 32'(done_count), 32'(dc + 1));

        // Reset mid-SEND aborts without a done pulse.
        dc = done_count;
        launch(4'd0, 5'd4);
        step();
        check("send_pre_rst", 32'({bus.data_valid, busy}), 32'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_send", 32'({bus.data_valid, busy, bus.last, bus.data_out}), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst_no_done", 32'(done_count), 32'(dc));
        check("rst_idle", 32'({busy, bus.data_valid}), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Sequential read initiator for the team's combinational ROM. On a start request it walks a programmable address range, drives the ROM `address`/`read_enable`/`chip_enable` inputs, and registers each returned word. Each word is presented on a valid/ready byte stream with a last-beat marker. It sits between the ROM and any downstream consumer, such as a UART transmitter or display driver, that needs the stored string (e.g. "JARI") as a flow-controlled stream.

## Interface
Parameters:
- `data_width`, 8, width of ROM word and stream data.
- `memory_depth`, 16, number of ROM locations.
- `address_width`, `$clog2(memory_depth)`, ROM address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a read burst; sampled only in IDLE.
- `start_address`  in  address_width  first ROM address of the burst.
- `length`  in  address_width+1  number of words to read; 0 is legal.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse at burst completion.
- `address`  out  address_width  ROM address.
- `read_enable`  out  1  ROM read strobe.
- `chip_enable`  out  1  ROM select.
- `rom_data`  in  data_width  ROM data output, combinational w.r.t. `address`.
- `data_out`  out  data_width  stream data.
- `data_valid`  out  1  stream data valid.
- `data_ready`  in  1  downstream accept.
- `last`  out  1  marks final beat of burst; qualified by `data_valid`.

## Operation
- State machine: IDLE, FETCH, SEND, DONE. All outputs are registered.
- Reset (async): state IDLE. All outputs are 0: `busy`, `done`, `address`, `read_enable`, `chip_enable`, `data_out`, `data_valid`, `last`.
- IDLE:
  - `start`=1 with `length`≠0 latches `start_address` into the address counter and `length` into the remaining counter, then goes to FETCH.
  - `start`=1 with `length`=0 goes directly to DONE.
- FETCH:
  - `chip_enable`=`read_enable`=1 and `address` = counter, for exactly one cycle.
  - At the end of the cycle, `rom_data` is captured into `data_out`. `last` is set if remaining==1. Next state is SEND.
- SEND:
  - `data_valid`=1. `data_out` and `last` are held stable until `data_valid`&`data_ready`.
  - `chip_enable` and `read_enable` are 0.
  - On handshake:
    - Address increments modulo `memory_depth`: `memory_depth-1` wraps to 0, including non-power-of-2 depths.
    - Remaining decrements.
    - If remaining was 1, go to DONE. Otherwise go to FETCH.
  - `data_valid` drops in the cycle after the handshake.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `busy`=1 in FETCH and SEND only.
- `start` outside IDLE is ignored; a burst is never restarted or extended.
- `length` values greater than `memory_depth` are legal. Reads continue past the wrap and revisit addresses.
- `rst_n` asserted mid-burst aborts immediately to reset values. No `done` pulse is issued for the aborted burst.

## Timing
- `start` sampled high at edge N (IDLE):
  - FETCH during cycle N+1.
  - `data_valid` high from N+2.
- `data_ready` held high: one beat per 2 cycles; first beat in cycle N+2.
- Final handshake at edge M: `done` high during cycle M+1 and `data_valid` low in M+1. IDLE in M+2, where a new `start` is accepted.
- `length`=0: `done` high in cycle N+1. No ROM access and no `data_valid`.
- `data_ready` low: the beat stalls indefinitely with `data_out` and `last` unchanged. No ROM access occurs while stalled.
- `data_ready` asserted when `data_valid` is low has no effect.

## Test plan
ROM contents: 0x4A, 0x41, 0x52, 0x49 at addresses 0-3, zero elsewhere; `memory_depth`=16.
- Reset values: assert `rst_n`=0 mid-FETCH → all outputs 0 asynchronously. After release, `start`=1 is accepted normally.
- Basic burst: `start_address`=0, `length`=4, `data_ready`=1.
  - Beats 0x4A, 0x41, 0x52, 0x49 in cycles N+2, N+4, N+6, N+8.
  - `last` on 0x49 only; `done` in N+9.
- Backpressure: same burst with `data_ready` low for 5 cycles on beat 2 → 0x41 held stable with `data_valid`=1 throughout. No `read_enable` pulses while stalled. Sequence unchanged.
- Wrap-around: `start_address`=14, `length`=4 → addresses 14, 15, 0, 1; data 0x00, 0x00, 0x4A, 0x41. `last` on 0x41.
- Zero length and ignored start: `length`=0 → `done` in N+1 with no `chip_enable`. `start` pulsed during a busy burst → no effect on address, count or `done` count.
- Reset mid-SEND: `rst_n` low while `data_valid`=1 → `data_valid`, `busy` and `last` go 0 immediately. No `done` pulse follows.
